grid_step_scheduler: RTL and testbench

Sequences the 64-column heat-grid datapath. It issues solver step pulses to the column array and waits for every column to report completion. After a programmed number of steps it scans all nodes, colour-maps each amplitude to an 8-bit RGB332 pixel and writes the pixels to VGA pixel memory through a request/ack handshake. It sits between the HPS control registers (run, single_step, steps_per_frame) and both the column array and the pixel-memory writer.

---
 rtl/grid_step_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_grid_step_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_step_scheduler.sv
// -----------------------------------------------------------------------------
// grid_step_scheduler
//
// Sequences the heat-grid column array and the pixel-memory writer. Each frame
// issues steps_per_frame solver steps (col_start pulse, guard window, wait for
// all col_done flags), then scans every node, colour-maps its amplitude to an
// RGB332 pixel and writes it to pixel memory through a request/ack handshake.
//
// Ports:
//   i_clk_50            system clock
//   i_reset             synchronous, active-high reset
//   i_run               level, free-running frames while high
//   i_single_step       pulse, runs exactly one frame when idle
//   i_steps_per_frame   solver steps per frame (0 behaves as 1)
//   i_col_done          per-column completion flags (level)
//   o_col_start         one-cycle step pulse to all columns
//   o_rd_index          node select into the column output mux
//   i_node_val          signed node amplitude selected by o_rd_index
//   o_mem_write         pixel write request
//   o_mem_addr          pixel address
//   o_mem_data          RGB332 pixel
//   i_mem_ack           write accepted
//   o_frame_done        one-cycle pulse after the last pixel is acked
//   o_busy              high in every state except IDLE
//   o_step_count        solver steps issued since reset (wraps)
//
// DONE_GUARD and RD_LAT must both be at least 1.
// -----------------------------------------------------------------------------
module grid_step_scheduler #(
    parameter int NCOL       = 64,
    parameter int IDX_W      = 6,
    parameter int DONE_GUARD = 2,
    parameter int RD_LAT     = 1
) (
    input  logic              i_clk_50,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_single_step,
    input  logic [7:0]        i_steps_per_frame,
    input  logic [NCOL-1:0]   i_col_done,
    output logic              o_col_start,
    output logic [IDX_W-1:0]  o_rd_index,
    input  logic [31:0]       i_node_val,
    output logic              o_mem_write,
    output logic [IDX_W-1:0]  o_mem_addr,
    output logic [7:0]        o_mem_data,
    input  logic              i_mem_ack,
    output logic              o_frame_done,
    output logic              o_busy,
    output logic [15:0]       o_step_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GUARD,
        S_WAIT_DONE,
        S_SCAN,
        S_MAP,
        S_WRITE,
        S_FRAME
    } state_t;

    state_t             r_state;
    logic [7:0]         r_steps_left;
    logic [7:0]         r_cnt;          // shared GUARD / SCAN wait counter
    logic [IDX_W-1:0]   r_index;
    logic               r_col_start;
    logic [IDX_W-1:0]   r_rd_index;
    logic               r_mem_write;
    logic [IDX_W-1:0]   r_mem_addr;
    logic [7:0]         r_mem_data;
    logic               r_frame_done;
    logic               r_busy;
    logic [15:0]        r_step_count;

    logic               w_all_done;
    logic               w_last_pix;
    logic [7:0]         w_steps_load;

    assign w_all_done   = &i_col_done;
    assign w_last_pix   = (r_index == IDX_W'(NCOL - 1));
    assign w_steps_load = (i_steps_per_frame == 8'd0) ? 8'd1 : i_steps_per_frame;

    // Amplitude bands, signed, highest band first.
    function automatic logic [7:0] f_cmap(input logic [31:0] v);
        logic signed [31:0] sv;
        sv = $signed(v);
        if      (sv >= 32'sh3000_0000)    return 8'hE0;
        else if (sv >= 32'sh2000_0000)    return 8'hE8;
        else if (sv >= 32'sh1000_0000)    return 8'hCD;
        else if (sv >= 32'sh0000_0000)    return 8'h00;
        else if (sv >= -32'sh1000_0000)   return 8'h77;
        else if (sv >= -32'sh2000_0000)   return 8'hF8;
        else if (sv >= -32'sh3000_0000)   return 8'hE3;
        else                              return 8'hFF;
    endfunction

    always_ff @(posedge i_clk_50) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_steps_left <= '0;
            r_cnt        <= '0;
            r_index      <= '0;
            r_col_start  <= 1'b0;
            r_rd_index   <= '0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_step_count <= '0;
        end else begin
            // single-cycle pulses default low
            r_col_start  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // run and single_step together still give one START
                    if (i_run || i_single_step) begin
                        r_steps_left <= w_steps_load;
                        r_state      <= S_START;
                        r_col_start  <= 1'b1;
                        r_step_count <= r_step_count + 16'd1;
                        r_busy       <= 1'b1;
                    end
                end
                S_START: begin
                    r_cnt   <= 8'(DONE_GUARD - 1);
                    r_state <= S_GUARD;
                end
                S_GUARD: begin
                    // stale col_done from the previous step is ignored here
                    if (r_cnt == 8'd0) r_state <= S_WAIT_DONE;
                    else               r_cnt   <= r_cnt - 8'd1;
                end
                S_WAIT_DONE: begin
                    if (w_all_done) begin
                        r_steps_left <= r_steps_left - 8'd1;
                        if (r_steps_left == 8'd1) begin
                            r_index    <= '0;
                            r_rd_index <= '0;
                            r_cnt      <= 8'(RD_LAT - 1);
                            r_state    <= S_SCAN;
                        end else begin
                            r_col_start  <= 1'b1;
                            r_step_count <= r_step_count + 16'd1;
                            r_state      <= S_START;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_cnt == 8'd0) r_state <= S_MAP;
                    else               r_cnt   <= r_cnt - 8'd1;
                end
                S_MAP: begin
                    r_mem_data  <= f_cmap(i_node_val);
                    r_mem_addr  <= r_index;
                    r_mem_write <= 1'b1;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    // request stays fully stable until ack is sampled
                    if (i_mem_ack) begin
                        r_mem_write <= 1'b0;
                        if (w_last_pix) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_FRAME;
                        end else begin
                            r_index    <= r_index + IDX_W'(1);
                            r_rd_index <= r_index + IDX_W'(1);
                            r_cnt      <= 8'(RD_LAT - 1);
                            r_state    <= S_SCAN;
                        end
                    end
                end
                S_FRAME: begin
                    // run is only looked at here, so a frame always completes
                    if (i_run) begin
                        r_steps_left <= w_steps_load;
                        r_col_start  <= 1'b1;
                        r_step_count <= r_step_count + 16'd1;
                        r_state      <= S_START;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_col_start  = r_col_start;
    assign o_rd_index   = r_rd_index;
    assign o_mem_write  = r_mem_write;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_mem_data;
    assign o_frame_done = r_frame_done;
    assign o_busy       = r_busy;
    assign o_step_count = r_step_count;

endmodule

// File: tb/tb_grid_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_grid_step_scheduler
//
// Drives the scheduler with a behavioural column array (col_done timing modes,
// registered node read), a pixel-memory responder with variable ack delay, and
// a frame scoreboard computed from the colour-band table.
// -----------------------------------------------------------------------------
module tb_grid_step_scheduler;
    localparam int NCOL  = 64;
    localparam int IDX_W = 6;
    localparam int DG    = 2;
    localparam logic [NCOL-1:0] MASK17 = ~({{(NCOL-1){1'b0}}, 1'b1} << 17);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0;
    logic             single_step = 1'b0;
    logic [7:0]       spf = 8'd0;
    logic [NCOL-1:0]  col_done = '0;
    logic [31:0]      node_val = '0;
    logic             mem_ack = 1'b0;
    logic             col_start, mem_write, frame_done, busy;
    logic [IDX_W-1:0] rd_index, mem_addr;
    logic [7:0]       mem_data;
    logic [15:0]      step_count;

    grid_step_scheduler #(.NCOL(NCOL), .IDX_W(IDX_W), .DONE_GUARD(DG), .RD_LAT(1)) dut (
        .i_clk_50(clk), .i_reset(reset), .i_run(run), .i_single_step(single_step),
        .i_steps_per_frame(spf), .i_col_done(col_done), .o_col_start(col_start),
        .o_rd_index(rd_index), .i_node_val(node_val), .o_mem_write(mem_write),
        .o_mem_addr(mem_addr), .o_mem_data(mem_data), .i_mem_ack(mem_ack),
        .o_frame_done(frame_done), .o_busy(busy), .o_step_count(step_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // colour bands straight from the table: lower bound -> pixel
    int         band_lo  [7] = '{'h3000_0000, 'h2000_0000, 'h1000_0000, 0,
                                 -'h1000_0000, -'h2000_0000, -'h3000_0000};
    logic [7:0] band_pix [7] = '{8'hE0, 8'hE8, 8'hCD, 8'h00, 8'h77, 8'hF8, 8'hE3};

    function automatic logic [7:0] ref_pix(input logic [31:0] v);
        int sv;
        sv = int'(v);
        for (int k = 0; k < 7; k++)
            if (sv >= band_lo[k]) return band_pix[k];
        return 8'hFF;
    endfunction

    // ---------------- column array model ----------------
    logic [31:0] nodes [NCOL];
    int cd_mode = 0;   // 0: clear all, 1: stale all-ones, 2: only col 17 late
    int cd_dly  = 5;
    int cd_cnt  = 0;

    always @(posedge clk) node_val <= nodes[rd_index];

    always @(posedge clk) begin
        if (reset) begin
            cd_cnt <= 0;
        end else if (cd_mode == 1) begin
            col_done <= '1;
        end else if (col_start) begin
            cd_cnt   <= 1;
            col_done <= (cd_mode == 2) ? MASK17 : '0;
        end else if (cd_cnt != 0) begin
            if (cd_cnt == cd_dly) begin
                col_done <= '1;
                cd_cnt   <= 0;
            end else begin
                cd_cnt <= cd_cnt + 1;
            end
        end
    end

    // ---------------- pixel memory responder ----------------
    int ack_mode = 0;  // 0: fast, 1: 0/1/7 pattern, 2: random, 3: never
    int wcnt = 0;
    int cur_w = 0;
    logic drop_pend = 1'b0;
    logic [IDX_W-1:0] hold_addr;
    logic [7:0] hold_data;
    logic [IDX_W-1:0] wr_addr [$];
    logic [7:0]       wr_data [$];

    function automatic int pick_wait(input logic [IDX_W-1:0] a);
        case (ack_mode)
            0: return 0;
            1: begin
                case (int'(a) % 3)
                    0:       return 0;
                    1:       return 1;
                    default: return 7;
                endcase
            end
            2: return int'($urandom_range(0, 3));
            default: return 100000;
        endcase
    endfunction

    always @(posedge clk) begin
        int w;
        if (reset) begin
            mem_ack   <= 1'b0;
            wcnt      <= 0;
            drop_pend <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            if (drop_pend) begin
                chk("wr_drop", mem_write, 0);
                drop_pend <= 1'b0;
            end
            if (mem_ack && mem_write) begin
                drop_pend <= 1'b1;
            end else if (mem_write) begin
                if (wcnt == 0) begin
                    w = pick_wait(mem_addr);
                    hold_addr <= mem_addr;
                    hold_data <= mem_data;
                end else begin
                    w = cur_w;
                    chk("wr_addr_hold", mem_addr, hold_addr);
                    chk("wr_data_hold", mem_data, hold_data);
                end
                cur_w <= w;
                if (wcnt >= w) begin
                    mem_ack <= 1'b1;
                    wcnt    <= 0;
                    wr_addr.push_back(mem_addr);
                    wr_data.push_back(mem_data);
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else if (col_start) begin
                // stray ack with no request pending must be ignored
                mem_ack <= 1'b1;
            end
        end
    end

    // ---------------- frame scoreboard ----------------
    int cyc = 0;
    int total_starts = 0;
    int starts_in_frame = 0;
    int last_start = 0;
    int fcount = 0;
    int exp_steps = 1;
    int exp_int = 0;
    int exp_total = 0;
    int lat_chk = 0;
    int lat_exp = 0;
    int trig_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        int nexp;
        if (reset) begin
            starts_in_frame <= 0;
            exp_total       <= 0;
            wr_addr.delete();
            wr_data.delete();
        end else begin
            if (col_start) begin
                total_starts    <= total_starts + 1;
                starts_in_frame <= starts_in_frame + 1;
                if (starts_in_frame > 0 && exp_int > 0)
                    chk("step_interval", cyc - last_start, exp_int);
                last_start <= cyc;
            end
            if (frame_done) begin
                nexp = (exp_total + exp_steps) % 65536;
                chk("frame_nwr", wr_addr.size(), NCOL);
                for (int i = 0; i < wr_addr.size() && i < NCOL; i++) begin
                    chk($sformatf("pix_addr[%0d]", i), wr_addr[i], i);
                    chk($sformatf("pix_data[%0d]", i), wr_data[i], ref_pix(nodes[i]));
                end
                chk("frame_starts", starts_in_frame, exp_steps);
                chk("step_count", step_count, nexp);
                chk("busy_in_frame", busy, 1);
                if (lat_chk != 0) chk("latency", cyc - trig_cyc, lat_exp);
                exp_total       <= nexp;
                starts_in_frame <= 0;
                fcount          <= fcount + 1;
                wr_addr.delete();
                wr_data.delete();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic fill_nodes(input bit sweep);
        logic [31:0] r;
        for (int i = 0; i < NCOL; i++) begin
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r = {r[31:28], 28'h0};
            else if ($urandom_range(0, 3) == 0) r = {r[31:28], 28'h0} - 32'd1;
            nodes[i] = r;
        end
        if (sweep) begin
            nodes[0] = 32'h3000_0000; nodes[1] = 32'h2FFF_FFFF;
            nodes[2] = 32'h1000_0000; nodes[3] = 32'h0000_0000;
            nodes[4] = 32'hFFFF_FFFF; nodes[5] = 32'hE000_0000;
            nodes[6] = 32'hD000_0000; nodes[7] = 32'h8000_0000;
        end
    endtask

    task automatic trig(input bit r, input bit s, input bit keep_run);
        @(negedge clk);
        run = r; single_step = s; trig_cyc = cyc;
        @(negedge clk);
        single_step = 1'b0;
        if (!keep_run) run = 1'b0;
    endtask

    task automatic wait_fc(input int target, input int budget);
        for (int i = 0; i < budget && fcount < target; i++) @(negedge clk);
        chk("frame_timeout", fcount >= target, 1);
    endtask

    task automatic idle_check();
        int t0, f0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        t0 = total_starts; f0 = fcount;
        repeat (30) @(negedge clk);
        chk("idle_no_start", total_starts - t0, 0);
        chk("idle_no_frame", fcount - f0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_col_start"}, col_start, 0);
        chk({tag, "_rd_index"}, rd_index, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_data"}, mem_data, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_step_count"}, step_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        for (int i = 0; i < NCOL; i++) nodes[i] = '0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;

        // three steps, sweep of band edges, fast acks, run pulsed
        fill_nodes(1'b1);
        cd_mode = 0; cd_dly = 5; exp_int = cd_dly + 2; ack_mode = 0;
        spf = 8'd3; exp_steps = 3;
        trig(1'b1, 1'b0, 1'b0);
        wait_fc(1, 5000);
        idle_check();

        // stale all-ones col_done: guard alone sets step spacing; exact latency
        fill_nodes(1'b0);
        cd_mode = 1; exp_int = 1 + DG + 1; ack_mode = 0;
        spf = 8'd5; exp_steps = 5;
        lat_chk = 1; lat_exp = 5 * (1 + DG + 1) + NCOL * 4 + 1;
        trig(1'b0, 1'b1, 1'b0);
        repeat (60) @(negedge clk);
        single_step = 1'b1;
        @(negedge clk);
        single_step = 1'b0;
        wait_fc(2, 5000);
        lat_chk = 0;
        idle_check();

        // col 17 late, 0/1/7 ack delays, run and single_step together
        fill_nodes(1'b0);
        cd_mode = 2; cd_dly = 20; exp_int = cd_dly + 2; ack_mode = 1;
        spf = 8'd2; exp_steps = 2;
        trig(1'b1, 1'b1, 1'b0);
        wait_fc(3, 8000);
        idle_check();

        // randomized single frames
        for (int n = 0; n < 4; n++) begin
            fill_nodes(1'b0);
            cd_mode = 0; cd_dly = int'($urandom_range(2, 8)); exp_int = cd_dly + 2;
            ack_mode = 2;
            spf = 8'($urandom_range(0, 4));
            exp_steps = (spf == 8'd0) ? 1 : int'(spf);
            f = fcount;
            if ($urandom_range(0, 1) == 0) trig(1'b1, 1'b0, 1'b0);
            else                           trig(1'b0, 1'b1, 1'b0);
            wait_fc(f + 1, 8000);
            idle_check();
        end

        // free running with steps_per_frame=0, run dropped mid-scan
        fill_nodes(1'b0);
        cd_mode = 0; cd_dly = 5; exp_int = cd_dly + 2; ack_mode = 0;
        spf = 8'd0; exp_steps = 1;
        f = fcount;
        trig(1'b1, 1'b0, 1'b1);
        wait_fc(f + 2, 8000);
        begin
            int k;
            for (k = 0; k < 3000; k++) begin
                @(negedge clk);
                if (mem_write && mem_addr >= IDX_W'(10)) break;
            end
            chk("midscan_timeout", k < 3000, 1);
        end
        run = 1'b0;
        wait_fc(f + 3, 5000);
        idle_check();

        // reset while a write is waiting for ack
        fill_nodes(1'b0);
        cd_mode = 0; cd_dly = 3; exp_int = cd_dly + 2; ack_mode = 3;
        spf = 8'd1; exp_steps = 1;
        trig(1'b0, 1'b1, 1'b0);
        begin
            int k;
            for (k = 0; k < 500; k++) begin
                @(negedge clk);
                if (mem_write) break;
            end
            chk("write_wait_timeout", mem_write, 1);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        ack_mode = 0; spf = 8'd2; exp_steps = 2;
        f = fcount;
        trig(1'b0, 1'b1, 1'b0);
        wait_fc(f + 1, 5000);
        idle_check();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
